// File: rtl/alu_share_arb.sv
// alu_share_arb: time-shares one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module alu_share_arb #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [3:0]       alu_ctrl_o,
    output logic [XLEN-1:0]  alu_a_o,
    output logic [XLEN-1:0]  alu_b_o,
    input  logic [XLEN-1:0]  alu_result_i,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [XLEN-1:0]  rsp0_result,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [XLEN-1:0]  rsp1_result,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t             state;
    logic               owner;
    logic [3:0]         ctrl_q;
    logic [XLEN-1:0]    a_q;
    logic [XLEN-1:0]    b_q;
    logic [XLEN-1:0]    result_q;
    logic [TAG_W-1:0]   tag_q;
    logic               grant1;
    logic               accept;
    logic               idle;
    logic               exec;
    logic               resp;
`ifdef ALU_ARB_RR_EN
    logic               last_grant;
    always_comb grant1 = req1_valid & (~req0_valid | ~last_grant);
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant1;
    end
`else
    always_comb grant1 = req1_valid & ~req0_valid;
`endif
    always_comb begin
        idle        = ~rst & (state == IDLE);
        exec        = ~rst & (state == EXEC);
        resp        = ~rst & (state == RESP);
        req0_ready  = idle & req0_valid & ~grant1;
        req1_ready  = idle & grant1;
        accept      = req0_ready | req1_ready;
        alu_ctrl_o  = exec ? ctrl_q : 4'd0;
        alu_a_o     = exec ? a_q : '0;
        alu_b_o     = exec ? b_q : '0;
        rsp0_valid  = resp & ~owner;
        rsp1_valid  = resp & owner;
        rsp0_result = rsp0_valid ? result_q : '0;
        rsp0_tag    = rsp0_valid ? tag_q : '0;
        rsp1_result = rsp1_valid ? result_q : '0;
        rsp1_tag    = rsp1_valid ? tag_q : '0;
        busy        = ~rst & (state != IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            ctrl_q   <= 4'd0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state  <= EXEC;
                    owner  <= grant1;
                    ctrl_q <= grant1 ? req1_ctrl : req0_ctrl;
                    a_q    <= grant1 ? req1_a : req0_a;
                    b_q    <= grant1 ? req1_b : req0_b;
                    tag_q  <= grant1 ? req1_tag : req0_tag;
                end
                EXEC: begin
                    result_q <= alu_result_i;
                    state    <= RESP;
                end
                RESP: if (owner ? rsp1_ready : rsp0_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: scoreboard bench for alu_share_arb; the bench itself plays the shared ALU.
module tb_alu_share_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_tag = '0, req1_tag = '0;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_a_o, alu_b_o, alu_result_i;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  rsp0_tag, rsp1_tag;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic [35:0] e0, e1;
    bit          tie_g[$];

    alu_share_arb #(.XLEN(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .alu_ctrl_o(alu_ctrl_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_result_i(alu_result_i),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_tag(rsp1_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return {31'd0, $signed(a) < $signed(b)};
            4'd6: return {31'd0, a < b};
            4'd7: return a << b[4:0];
            4'd8: return a >> b[4:0];
            4'd9: return $signed(a) >>> b[4:0];
            default: return a ^ b ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    always_comb alu_result_i = alu_f(alu_ctrl_o, alu_a_o, alu_b_o);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            check("ready_excl", {63'd0, req0_ready & req1_ready}, 64'd0);
            if (req0_valid && req0_ready) q0.push_back({req0_tag, alu_f(req0_ctrl, req0_a, req0_b)});
            if (req1_valid && req1_ready) q1.push_back({req1_tag, alu_f(req1_ctrl, req1_a, req1_b)});
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) check("rsp0_spurious", 64'd1, 64'd0);
                else begin
                    e0 = q0.pop_front();
                    check("rsp0_result", {32'd0, rsp0_result}, {32'd0, e0[31:0]});
                    check("rsp0_tag", {60'd0, rsp0_tag}, {60'd0, e0[35:32]});
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) check("rsp1_spurious", 64'd1, 64'd0);
                else begin
                    e1 = q1.pop_front();
                    check("rsp1_result", {32'd0, rsp1_result}, {32'd0, e1[31:0]});
                    check("rsp1_tag", {60'd0, rsp1_tag}, {60'd0, e1[35:32]});
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_rsp_valid", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        check("rst_alu", {alu_ctrl_o, alu_a_o, alu_b_o[27:0]}, 64'd0);
        check("rst_rsp_data", {rsp0_result, rsp1_result}, 64'd0);
        req0_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic issue(input bit r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        bit got = 1'b0;
        if (r) {req1_valid, req1_ctrl, req1_a, req1_b, req1_tag} = {1'b1, c, a, b, t};
        else {req0_valid, req0_ctrl, req0_a, req0_b, req0_tag} = {1'b1, c, a, b, t};
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = r ? req1_ready : req0_ready;
        end
        check("issue_accept", {63'd0, got}, 64'd1);
        @(posedge clk);
        #1;
        if (r) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk);
            #1;
            done = !busy && q0.size() == 0 && q1.size() == 0;
        end
        check("drain", {63'd0, done}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1;
        do_reset();
        // single request: SUB 10-3
        issue(1'b0, 4'd1, 32'd10, 32'd3, 4'd5);
        @(negedge clk);
        check("sub_exec_ctrl", {60'd0, alu_ctrl_o}, 64'd1);
        check("sub_exec_ops", {alu_a_o, alu_b_o}, {32'd10, 32'd3});
        check("sub_exec_busy", {62'd0, busy, req0_ready}, 64'd2);
        @(negedge clk);
        check("sub_rsp_valid", {62'd0, rsp0_valid, rsp1_valid}, 64'd2);
        check("sub_rsp", {28'd0, rsp0_tag, rsp0_result}, {28'd0, 4'd5, 32'd7});
        check("sub_nonowner", {28'd0, rsp1_tag, rsp1_result}, 64'd0);
        drain();
        // backpressure on requester 1 with requester 0 waiting
        rsp1_ready = 1'b0;
        issue(1'b1, 4'd9, 32'h8000_0000, 32'd4, 4'd9);
        {req0_valid, req0_ctrl, req0_a, req0_b, req0_tag} = {1'b1, 4'd0, 32'd5, 32'd6, 4'd3};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {62'd0, rsp1_valid, rsp0_valid}, 64'd2);
            check("bp_result", {32'd0, rsp1_result}, 64'hF800_0000);
            check("bp_busy", {62'd0, busy, req0_ready}, 64'd2);
        end
        @(posedge clk);
        #1 rsp1_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {63'd0, req0_ready}, 64'd0);
        issue(1'b0, 4'd0, 32'd5, 32'd6, 4'd3);
        drain();
        // tie between both requesters
        do_reset();
        {req0_valid, req0_ctrl, req0_a, req0_b, req0_tag} = {1'b1, 4'd0, 32'd1, 32'd1, 4'd1};
        {req1_valid, req1_ctrl, req1_a, req1_b, req1_tag} = {1'b1, 4'd4, 32'hF, 32'h3, 4'd2};
        for (int i = 0; i < 40 && tie_g.size() < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) tie_g.push_back(req1_ready);
        end
        @(posedge clk);
        #1 {req0_valid, req1_valid} = 2'b00;
        check("tie_count", 64'(tie_g.size()), 64'd4);
        for (int i = 0; i < tie_g.size(); i++)
`ifdef ALU_ARB_RR_EN
            check("tie_grant", {63'd0, tie_g[i]}, 64'(i % 2));
`else
            check("tie_grant", {63'd0, tie_g[i]}, 64'd0);
`endif
        drain();
        // reset during EXEC discards the operation
        issue(1'b0, 4'd6, 32'd1, 32'd2, 4'd7);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rmid_idle", {62'd0, busy, rsp0_valid}, 64'd0);
        check("rmid_alu", {28'd0, alu_ctrl_o, alu_a_o}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rmid_no_rsp", {63'd0, rsp0_valid}, 64'd0);
        end
        check("rmid_sb_empty", 64'(q0.size()), 64'd0);
        // unassigned control code passes straight through
        @(posedge clk);
        #1;
        issue(1'b0, 4'hF, 32'h1234, 32'h00FF, 4'hA);
        @(negedge clk);
        check("ill_ctrl", {60'd0, alu_ctrl_o}, 64'hF);
        @(negedge clk);
        check("ill_rsp", {31'd0, rsp0_valid, rsp0_result}, {31'd1, alu_f(4'hF, 32'h1234, 32'h00FF)});
        drain();
        check("final_q", 64'(q0.size() + q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
